// File: rtl/clk_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : clk_div_pkg                                                      |
// | Shared constants, per-channel ratio record and channel-index width helper  |
// | for the multi-channel clock-enable generator (clk_div_multi).              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package clk_div_pkg;

  // Supported channel count range
  localparam int unsigned CLK_DIV_NUM_CH_MIN  = 1;
  localparam int unsigned CLK_DIV_NUM_CH_MAX  = 16;

  // Ratio loaded into every channel at reset
  localparam int unsigned CLK_DIV_DEFAULT_DIV = 200;

  // Storage width of the ratio record; WIDTH must not exceed this
  localparam int unsigned CLK_DIV_MAX_WIDTH   = 32;

  // Per-channel ratio state: active ratio, staged ratio and its valid flag
  typedef struct packed {
    logic [CLK_DIV_MAX_WIDTH-1:0] div;
    logic [CLK_DIV_MAX_WIDTH-1:0] shadow;
    logic                         pending;
  } ch_cfg_t;

  // Channel-select width: at least one bit even for a single channel
  function automatic int unsigned clk_div_ch_w(input int unsigned num_ch);
    return (num_ch <= 32'd1) ? 32'd1 : 32'($clog2(num_ch));
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clk_div_channel                                                  |
// | One divider channel: period counter, shadow/pending ratio update applied   |
// | only at period wrap (or while disabled), registered tick and, when         |
// | DIV_WAVE_OUT_EN is defined, a registered ~50% duty divided waveform.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT_DIV
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_div_in,
  output logic             pending_out,
  output logic             tick_out
`ifdef DIV_WAVE_OUT_EN
  ,
  output logic             div_out
`endif
);

  localparam ch_cfg_t CFG_RST = '{
    div:     CLK_DIV_MAX_WIDTH'(DEFAULT_DIV),
    shadow:  CLK_DIV_MAX_WIDTH'(DEFAULT_DIV),
    pending: 1'b0
  };

  ch_cfg_t                      cfg_q, cfg_d;
  logic [WIDTH-1:0]             cnt_q, cnt_d;
  logic                         tick_q, tick_d;
  logic [CLK_DIV_MAX_WIDTH-1:0] w_cnt_ext;
  logic                         w_wrap;
  logic                         w_apply;

  assign w_cnt_ext = CLK_DIV_MAX_WIDTH'(cnt_q);
  assign w_wrap    = (w_cnt_ext == (cfg_q.div - CLK_DIV_MAX_WIDTH'(1)));
  // A staged ratio only lands on a period boundary, or immediately while idle
  assign w_apply   = cfg_q.pending & (~en_in | w_wrap);

  // Next-state: count, wrap/tick, staged-ratio promotion, then new request capture
  always_comb begin
    cfg_d  = cfg_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!en_in) begin
      cnt_d = '0;
    end else if (w_wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end
    if (w_apply) begin
      cfg_d.div     = cfg_q.shadow;
      cfg_d.pending = 1'b0;
    end
    // Top only loads when this channel had nothing pending, so no conflict with w_apply
    if (load_in) begin
      cfg_d.shadow  = CLK_DIV_MAX_WIDTH'(load_div_in);
      cfg_d.pending = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q  <= CFG_RST;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign pending_out = cfg_q.pending;
  assign tick_out    = tick_q;

`ifdef DIV_WAVE_OUT_EN
  logic                         div_out_q, div_out_d;
  logic [CLK_DIV_MAX_WIDTH-1:0] w_half;

  // ceil(div/2) of the ratio in force after this edge
  assign w_half = (cfg_d.div + CLK_DIV_MAX_WIDTH'(1)) >> 1;

  // Waveform: set on every tick, cleared when the count reaches ceil(div/2)
  always_comb begin
    div_out_d = div_out_q;
    if (!en_in) begin
      div_out_d = 1'b0;
    end else if (w_wrap) begin
      div_out_d = 1'b1;
    end else if (CLK_DIV_MAX_WIDTH'(cnt_d) == w_half) begin
      div_out_d = 1'b0;
    end
  end

  // Waveform register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_out_q <= 1'b0;
    end else begin
      div_out_q <= div_out_d;
    end
  end

  assign div_out = div_out_q;
`endif

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clk_div_multi                                                    |
// | NUM_CH runtime-programmable clock-enable generators on one system clock.   |
// | Decodes the valid/ready ratio-configuration port, flags rejected requests  |
// | on cfg_err and fans accepted ratios out to the channels.                   |
// | Optional feature macro: DIV_WAVE_OUT_EN (adds div_out waveform port).      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT_DIV
) (
  input  logic                              clk_in,
  input  logic                              rst_n,
  input  logic [NUM_CH-1:0]                 ch_en_in,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [clk_div_ch_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]                  cfg_div,
  output logic                              cfg_err,
  output logic [NUM_CH-1:0]                 tick_out
`ifdef DIV_WAVE_OUT_EN
  ,
  output logic [NUM_CH-1:0]                 div_out
`endif
);

  localparam int unsigned CH_W    = clk_div_ch_w(NUM_CH);
  localparam int unsigned CH_SPAN = 2 ** CH_W;

  if ((NUM_CH < CLK_DIV_NUM_CH_MIN) || (NUM_CH > CLK_DIV_NUM_CH_MAX) ||
      (WIDTH > CLK_DIV_MAX_WIDTH)) begin : g_bad_params
    $error("clk_div_multi: NUM_CH or WIDTH out of supported range");
  end

  logic [NUM_CH-1:0]  w_pending;
  logic [CH_SPAN-1:0] w_pending_pad;
  logic [NUM_CH-1:0]  w_load;
  logic               w_ch_ok;
  logic               w_accept;
  logic               w_bad;
  logic               cfg_err_q, cfg_err_d;

  assign w_ch_ok = (32'(cfg_ch) < NUM_CH);

  // Pad pending flags to the full index range so any cfg_ch value is a legal select
  always_comb begin
    w_pending_pad               = '0;
    w_pending_pad[NUM_CH-1:0]   = w_pending;
  end

  // An out-of-range index is always ready so it is consumed (and rejected), never stuck
  assign cfg_ready = w_ch_ok ? ~w_pending_pad[cfg_ch] : 1'b1;
  assign w_accept  = cfg_valid & cfg_ready;
  assign w_bad     = (cfg_div == '0) | ~w_ch_ok;

  // Error pulse for an accepted but discarded request
  always_comb begin
    cfg_err_d = w_accept & w_bad;
  end

  // Error pulse register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_load[i] = w_accept & ~w_bad & (cfg_ch == CH_W'(i));

    clk_div_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_channel (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .en_in       (ch_en_in[i]),
      .load_in     (w_load[i]),
      .load_div_in (cfg_div),
      .pending_out (w_pending[i]),
      .tick_out    (tick_out[i])
`ifdef DIV_WAVE_OUT_EN
      ,
      .div_out     (div_out[i])
`endif
    );
  end

endmodule
`default_nettype wire
